// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP datapath modules.
// Field widths, bias, integer saturation limits and a field-level classifier.
package fp_pkg;

    localparam int unsigned FP_EXP_BIAS = 127;
    localparam int unsigned FP_EXP_W    = 8;
    localparam int unsigned FP_FRAC_W   = 23;
    localparam int unsigned FP_SIG_W    = FP_FRAC_W + 1;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        FP_CLS_ZERO,
        FP_CLS_NORMAL,
        FP_CLS_INF,
        FP_CLS_NAN
    } fp_class_t;

    // Denormals fold into ZERO: their magnitude is far below one.
    function automatic fp_class_t fp_classify(input fp32_t x);
        fp_class_t cls;
        if (x.exp == '0) begin
            cls = FP_CLS_ZERO;
        end else if (x.exp == '1) begin
            cls = (x.frac == '0) ? FP_CLS_INF : FP_CLS_NAN;
        end else begin
            cls = FP_CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Aligns a 24-bit significand by unbiased exponent E into a 31-bit integer
// magnitude (fraction bits truncated), flagging E>=31 as overflow.
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [FP_SIG_W-1:0] sig,
    input  logic signed [9:0]   exp_unb,
    output logic [30:0]         mag,
    output logic                ovf
);

    // The significand is parked at the top of the 31-bit window (E=30) so a
    // single right shift by 30-E covers both the E<=23 and E>23 cases.
    logic [30:0] base;
    logic [4:0]  amt;

    assign base = {sig, 7'b0};
    assign amt  = 5'(10'sd30 - exp_unb);

    function automatic logic [30:0] barrel_right(input logic [30:0] x,
                                                 input logic [4:0]  n);
        logic [30:0] r;
        r = x;
        for (int unsigned i = 0; i < 5; i++) begin
            if (n[i]) begin
                r = r >> (1 << i);
            end
        end
        return r;
    endfunction

    always_comb begin
        mag = '0;
        ovf = 1'b0;
        if (exp_unb > 10'sd30) begin
            ovf = 1'b1;
        end else if (exp_unb >= 10'sd0) begin
            mag = barrel_right(base, amt);
        end
    end

endmodule

// File: rtl/float_to_signed_int.sv
// IEEE-754 single to 32-bit signed integer, truncating toward zero with
// saturation; one registered stage with a valid flag.
module float_to_signed_int
    import fp_pkg::*;
#(
    parameter int unsigned FP_W  = 32,
    parameter int unsigned INT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [FP_W-1:0]  FP_val,
    output logic             out_vld,
    output logic [INT_W-1:0] signed_int_val
);

    fp32_t           fp;
    fp_class_t       cls;
    logic signed [9:0] exp_unb;
    logic [30:0]     mag;
    logic            ovf;
    logic [31:0]     mag_ext;
    logic [31:0]     sat_val;
    logic [INT_W-1:0] conv;

    assign fp      = fp32_t'(FP_val);
    assign cls     = fp_classify(fp);
    assign exp_unb = $signed({2'b00, fp.exp}) - 10'sd127;

    fp_align_shift u_align (
        .sig     ({1'b1, fp.frac}),
        .exp_unb (exp_unb),
        .mag     (mag),
        .ovf     (ovf)
    );

    assign mag_ext = {1'b0, mag};
    assign sat_val = fp.sign ? INT_MIN : INT_MAX;

    // -2^31 lands on the overflow path and saturates to INT_MIN, which is exact.
    always_comb begin
        conv = '0;
        unique case (cls)
            FP_CLS_ZERO: conv = '0;
            FP_CLS_NAN:  conv = '0;
            FP_CLS_INF:  conv = sat_val;
            FP_CLS_NORMAL: begin
                if (ovf) begin
                    conv = sat_val;
                end else if (fp.sign) begin
                    conv = ~mag_ext + 32'd1;
                end else begin
                    conv = mag_ext;
                end
            end
            default: conv = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld        <= 1'b0;
            signed_int_val <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                signed_int_val <= conv;
            end
        end
    end

endmodule

// File: tb/tb_float_to_signed_int.sv
// Scoreboard bench: the driver pushes the expected output for every cycle it
// drives, and an independent monitor pops and compares one cycle later.
module tb_float_to_signed_int;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic [31:0] FP_val = '0;
    logic        out_vld;
    logic [31:0] signed_int_val;

    always #5 clk = ~clk;

    float_to_signed_int #(.FP_W(32), .INT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_vld         (in_vld),
        .FP_val         (FP_val),
        .out_vld        (out_vld),
        .signed_int_val (signed_int_val)
    );

    typedef struct {
        string       name;
        logic        vld;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] held  = '0;

    task automatic drive(input string name, input logic r, input logic v,
                         input logic [31:0] fpv, input logic [31:0] expv);
        exp_t e;
        @(negedge clk);
        rst    = r;
        in_vld = v;
        FP_val = fpv;
        e.name = name;
        if (r) begin
            held  = '0;
            e.vld = 1'b0;
            e.val = '0;
        end else if (v) begin
            held  = expv;
            e.vld = 1'b1;
            e.val = expv;
        end else begin
            e.vld = 1'b0;
            e.val = held;
        end
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (out_vld !== e.vld || signed_int_val !== e.val) begin
                    bad++;
                    $display("FAIL %s: got vld=%0b val=%h, want vld=%0b val=%h",
                             e.name, out_vld, signed_int_val, e.vld, e.val);
                end
            end
        end
    end

    typedef struct {
        string       name;
        logic [31:0] fpv;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[] = '{
        '{"neg2p5",    32'hC020_0000, 32'hFFFF_FFFE},
        '{"p0p75",     32'h3F40_0000, 32'h0000_0000},
        '{"neg0p5",    32'hBF00_0000, 32'h0000_0000},
        '{"p123456",   32'h47F1_2035, 32'd123456},
        '{"big",       32'h4EFF_FFFF, 32'h7FFF_FF80},
        '{"two31",     32'h4F00_0000, 32'h7FFF_FFFF},
        '{"negtwo31",  32'hCF00_0000, 32'h8000_0000},
        '{"pinf",      32'h7F80_0000, 32'h7FFF_FFFF},
        '{"ninf",      32'hFF80_0000, 32'h8000_0000},
        '{"nan",       32'h7FC0_0000, 32'h0000_0000},
        '{"negnan",    32'hFFC0_0001, 32'h0000_0000},
        '{"zero",      32'h0000_0000, 32'h0000_0000},
        '{"negzero",   32'h8000_0000, 32'h0000_0000},
        '{"denorm",    32'h0000_0001, 32'h0000_0000},
        '{"neg1",      32'hBF80_0000, 32'hFFFF_FFFF},
        '{"p16777217", 32'h4B80_0001, 32'd16777218},
        '{"neg1p999",  32'hBFFF_FFFF, 32'hFFFF_FFFF}
    };

    initial begin : stimulus
        int unsigned w, k, v;
        logic [31:0] mag, fpv, expv;
        logic [23:0] sig;
        logic        s;

        drive("rst0", 1'b1, 1'b1, 32'h3F80_0000, '0);
        drive("rst1", 1'b1, 1'b1, 32'h3F80_0000, '0);
        drive("post_rst", 1'b0, 1'b0, 32'h3F80_0000, '0);
        drive("one", 1'b0, 1'b1, 32'h3F80_0000, 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].name, 1'b0, 1'b1, vecs[i].fpv, vecs[i].expv);
        end

        // Random integers encoded exactly as floats, back to back.
        for (int n = 0; n < 100; n++) begin
            w    = $urandom_range(24, 1);
            v    = (32'd1 << (w - 1)) | ($urandom & ((32'd1 << (w - 1)) - 1));
            k    = $urandom_range(31 - w, 0);
            mag  = v << k;
            sig  = 24'(v << (24 - w));
            s    = 1'($urandom);
            fpv  = {s, 8'(w - 1 + k + 127), sig[22:0]};
            expv = s ? (~mag + 32'd1) : mag;
            drive("stream", 1'b0, 1'b1, fpv, expv);
        end

        drive("gap0", 1'b0, 1'b0, 32'h4000_0000, '0);
        drive("gap1", 1'b0, 1'b0, 32'hC000_0000, '0);
        drive("after_gap", 1'b0, 1'b1, 32'h4120_0000, 32'd10);
        drive("gap2", 1'b0, 1'b0, 32'h0, '0);

        drive("pre_rst", 1'b0, 1'b1, 32'h42C8_0000, 32'd100);
        drive("mid_rst", 1'b1, 1'b1, 32'h4348_0000, '0);
        drive("post_mid_rst", 1'b0, 1'b0, 32'h4348_0000, '0);
        drive("resume", 1'b0, 1'b1, 32'hC2C8_0000, 32'hFFFF_FF9C);
        drive("idle", 1'b0, 1'b0, 32'h0, '0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
